// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_pkg
// Description : Shared types, constants and helpers for the waveform capture
//               and display path.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

    // Default display geometry and sample width
    localparam int H_RES    = 1280;
    localparam int V_RES    = 1024;
    localparam int SAMPLE_W = 10;
    localparam int COORD_W  = 12;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Screen row for a sample: full scale at the top, zero at the bottom.
    // For an unsigned SAMPLE_W-bit value, (2**SAMPLE_W - 1) - s is simply ~s.
    function automatic logic [SAMPLE_W-1:0] sample_to_y(input logic [SAMPLE_W-1:0] s);
        return ~s;
    endfunction

endpackage : wave_pkg
`default_nettype wire

// File: rtl/wave_dpram.sv
`default_nettype none
// ============================================================================
// Module      : wave_dpram
// Description : Two-bank sample memory, one synchronous write port and one
//               synchronous read port (1-clk read latency). Address MSB
//               selects the bank, the remaining bits the word in the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_dpram
    import wave_pkg::*;
#(
    parameter int WORDS  = wave_pkg::H_RES,
    parameter int ADDR_W = $clog2(WORDS) + 1,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Banked storage keeps exactly WORDS entries per bank even when WORDS is
    // not a power of two, while the bank select stays on the address MSB.
    logic [DATA_W-1:0] r_mem [0:1][0:WORDS-1];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr[ADDR_W-1]][waddr[ADDR_W-2:0]] <= wdata;
        end
        rdata <= r_mem[raddr[ADDR_W-1]][raddr[ADDR_W-2:0]];
    end

endmodule : wave_dpram
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture
// Description : Triggered capture of one screen-width of audio samples into a
//               double-buffered memory, and raster read-back producing
//               wave_cond for pixels covered by the waveform trace.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture #(
    parameter int H_RES        = wave_pkg::H_RES,
    parameter int V_RES        = wave_pkg::V_RES,
    parameter int TRIG_LEVEL   = 512,
    parameter int TRIG_HYST    = 8,
    parameter int TRIG_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sample_tick,
    input  logic [wave_pkg::SAMPLE_W-1:0] wave_sample,
    input  logic                          switch,
    input  logic [wave_pkg::COORD_W-1:0]  VGA_HORZ_COORD,
    input  logic [wave_pkg::COORD_W-1:0]  VGA_VERT_COORD,
    output logic                          wave_cond,
    output logic                          capture_busy
);
    import wave_pkg::*;

    localparam int c_ptr_w = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_tmo_w = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

    localparam logic [c_ptr_w-1:0]  c_last_ptr = c_ptr_w'(H_RES - 1);
    localparam logic [c_tmo_w-1:0]  c_last_tmo = c_tmo_w'(TRIG_TIMEOUT - 1);
    localparam logic [SAMPLE_W-1:0] c_trig_hi  = SAMPLE_W'(TRIG_LEVEL);
    localparam logic [SAMPLE_W-1:0] c_trig_lo  = SAMPLE_W'(TRIG_LEVEL - TRIG_HYST);
    localparam logic [COORD_W-1:0]  c_h_res    = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0]  c_v_res    = COORD_W'(V_RES);

    // ------------------------------------------------------------------
    // Capture controller state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic                 r_armed_low;
    logic                 r_buf_sel;     // bank currently on screen
    logic                 r_buf_valid;   // a completed capture has been swapped in

    logic                 w_start;
    logic                 w_frame_edge;
    logic                 w_wr_en;
    logic [c_ptr_w-1:0]   w_wr_ptr;

    // Trigger (re-armed rising crossing) or timeout starts the capture
    always_comb begin
        w_start      = (r_armed_low && (wave_sample >= c_trig_hi)) || (r_tmo_cnt == c_last_tmo);
        w_frame_edge = (VGA_HORZ_COORD == '0) && (VGA_VERT_COORD == c_v_res);
    end

    // Write port: the starting sample lands at word 0, later ones at the pointer
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ptr = r_wr_ptr;
        if (sample_tick) begin
            if (r_state == ARMED && w_start) begin
                w_wr_en  = 1'b1;
                w_wr_ptr = '0;
            end else if (r_state == CAPTURING) begin
                w_wr_en  = 1'b1;
            end
        end
    end

    // Capture FSM; capture_busy is registered alongside the state it mirrors
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_tmo_cnt    <= '0;
            r_armed_low  <= 1'b0;
            r_buf_sel    <= 1'b0;
            r_buf_valid  <= 1'b0;
            capture_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state      <= ARMED;
                    r_tmo_cnt    <= '0;
                    r_armed_low  <= 1'b0;
                    capture_busy <= 1'b1;
                end
                ARMED: begin
                    if (sample_tick) begin
                        if (w_start) begin
                            r_state  <= CAPTURING;
                            r_wr_ptr <= c_ptr_w'(1);
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                            if (wave_sample < c_trig_lo) begin
                                r_armed_low <= 1'b1;
                            end
                        end
                    end
                end
                CAPTURING: begin
                    if (sample_tick) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == c_last_ptr) begin
                            r_state      <= DONE;
                            capture_busy <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Swap only in the first blanking line so a frame never
                    // mixes two buffers; a held freeze keeps the old trace.
                    if (w_frame_edge && !switch) begin
                        r_buf_sel   <= ~r_buf_sel;
                        r_buf_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    capture_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0]  r_rd_x;
    logic [c_ptr_w-1:0]  w_rd_x;
    logic [SAMPLE_W-1:0] w_s_cur;
    logic [SAMPLE_W-1:0] r_s_prev;
    logic                r_x0_d1;
    logic [COORD_W-1:0]  r_horz_d1;
    logic [COORD_W-1:0]  r_vert_d1;

    // Read address follows the beam inside the visible width, else holds
    always_comb begin
        w_rd_x = (VGA_HORZ_COORD < c_h_res) ? VGA_HORZ_COORD[c_ptr_w-1:0] : r_rd_x;
    end

    wave_dpram #(
        .WORDS  (H_RES),
        .ADDR_W (c_ptr_w + 1),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk    (clk),
        .we     (w_wr_en),
        .waddr  ({~r_buf_sel, w_wr_ptr}),
        .wdata  (wave_sample),
        .raddr  ({r_buf_sel, w_rd_x}),
        .rdata  (w_s_cur)
    );

    // Stage 1: hold read address, keep previous column's sample, delay coords
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_x    <= '0;
            r_s_prev  <= '0;
            r_x0_d1   <= 1'b0;
            r_horz_d1 <= '0;
            r_vert_d1 <= '0;
        end else begin
            r_rd_x    <= w_rd_x;
            r_s_prev  <= w_s_cur;
            r_x0_d1   <= (VGA_HORZ_COORD == '0);
            r_horz_d1 <= VGA_HORZ_COORD;
            r_vert_d1 <= VGA_VERT_COORD;
        end
    end

    logic [SAMPLE_W-1:0] w_y_cur;
    logic [SAMPLE_W-1:0] w_y_prev;
    logic [SAMPLE_W-1:0] w_y_lo;
    logic [SAMPLE_W-1:0] w_y_hi;
    logic                w_hit;

    // Vertical span between this column and the previous one joins the trace
    always_comb begin
        w_y_cur  = sample_to_y(w_s_cur);
        w_y_prev = sample_to_y(r_x0_d1 ? w_s_cur : r_s_prev);
        w_y_lo   = (w_y_cur < w_y_prev) ? w_y_cur  : w_y_prev;
        w_y_hi   = (w_y_cur < w_y_prev) ? w_y_prev : w_y_cur;
        w_hit    = (COORD_W'(w_y_lo) <= r_vert_d1) && (r_vert_d1 <= COORD_W'(w_y_hi));
    end

    // Stage 2: registered pixel decision, blanked outside the visible area
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wave_cond <= 1'b0;
        end else begin
            wave_cond <= r_buf_valid && (r_horz_d1 < c_h_res) && (r_vert_d1 < c_v_res) && w_hit;
        end
    end

endmodule : wave_capture
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_capture
// Description : Self-checking bench for wave_capture: directed capture
//               sequences, frame-boundary swaps, freeze, reset, and a table
//               of hand-computed trace pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_capture;

    localparam int H   = 32;
    localparam int V   = 1024;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_tick = 1'b0;
    logic [9:0]  wave_sample = '0;
    logic        sw = 1'b0;
    logic [11:0] hc = '0;
    logic [11:0] vc = '0;
    logic        wave_cond;
    logic        capture_busy;

    wave_capture #(
        .H_RES        (H),
        .V_RES        (V),
        .TRIG_LEVEL   (512),
        .TRIG_HYST    (8),
        .TRIG_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .sample_tick    (sample_tick),
        .wave_sample    (wave_sample),
        .switch         (sw),
        .VGA_HORZ_COORD (hc),
        .VGA_VERT_COORD (vc),
        .wave_cond      (wave_cond),
        .capture_busy   (capture_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   disp [H];
    int   back [H];
    int   t4   [H];
    bit   disp_valid = 1'b0;
    bit   line_res [H];
    vec_t vecs [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_coords();
        hc = 12'(H + 4);
        vc = 12'(V + 2);
    endtask

    task automatic push(input int v);
        sample_tick = 1'b1;
        wave_sample = 10'(v);
        step();
        sample_tick = 1'b0;
    endtask

    task automatic boundary();
        hc = '0;
        vc = 12'(V);
        step();
        idle_coords();
    endtask

    task automatic do_swap();
        for (int i = 0; i < H; i++) disp[i] = back[i];
        disp_valid = 1'b1;
    endtask

    // Scan one full line; wave_cond for column x appears two edges after it
    task automatic scan_line(input int y);
        for (int i = 0; i <= H; i++) begin
            hc = 12'(i);
            vc = 12'(y);
            step();
            if (i >= 1) line_res[i-1] = wave_cond;
        end
        idle_coords();
    endtask

    function automatic int model_pix(input int x, input int y);
        int yc, yp, lo, hi;
        if (!disp_valid) return 0;
        yc = 1023 - disp[x];
        yp = 1023 - disp[(x == 0) ? 0 : x - 1];
        lo = (yc < yp) ? yc : yp;
        hi = (yc < yp) ? yp : yc;
        return ((y >= lo) && (y <= hi)) ? 1 : 0;
    endfunction

    task automatic check_line(input string name, input int y);
        scan_line(y);
        for (int x = 0; x < H; x++) begin
            check($sformatf("%s x=%0d y=%0d", name, x, y), int'(line_res[x]), model_pix(x, y));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{10, 122, 0}, '{10, 123, 1}, '{10, 500, 1}, '{10, 923, 1}, '{10, 924, 0},
            '{ 9,  22, 0}, '{ 9,  23, 1}, '{ 9, 923, 1}, '{ 9, 924, 0},
            '{11, 124, 0}, '{11, 123, 1},
            '{ 0,  23, 1}, '{ 0,  24, 0},
            '{21,   0, 1}, '{21,   1, 0},
            '{26,1023, 1}, '{26,1022, 0}
        };
        for (int i = 0; i < H; i++) t4[i] = 1000;
        t4[9] = 100; t4[10] = 900; t4[20] = 1023; t4[21] = 1023; t4[25] = 0; t4[26] = 0;

        // Reset state
        idle_coords();
        #2;
        check("reset wave_cond", int'(wave_cond), 0);
        check("reset capture_busy", int'(capture_busy), 0);
        step(); step();
        resetn = 1'b1;
        step();
        check("armed busy", int'(capture_busy), 1);
        check_line("blank before swap", 23);

        // Ramp in steps of 16: arms on 0, triggers on 512
        for (int k = 0; k < 32; k++) push(16 * k);
        push(512); back[0] = 512;
        for (int i = 1; i < H; i++) begin
            if (i == H - 1) check("ramp busy before last", int'(capture_busy), 1);
            push(512 + 16 * i);
            back[i] = 512 + 16 * i;
        end
        check("ramp busy after last", int'(capture_busy), 0);
        check_line("ramp pre-swap blank", 511);
        hc = 12'd5; vc = 12'(V); step(); idle_coords();
        check_line("not a boundary", 511);
        boundary(); do_swap();
        check_line("ramp", 511);
        check("ramp s0 pixel", int'(line_res[0]), 1);
        check("ramp rearmed", int'(capture_busy), 1);

        // Never below the hysteresis band: timeout capture at tick TMO
        for (int k = 1; k < TMO + H; k++) begin
            if (k == TMO + H - 1) check("timeout busy before last", int'(capture_busy), 1);
            push(600 + k);
            if (k >= TMO) back[k - TMO] = 600 + k;
        end
        check("timeout busy after last", int'(capture_busy), 0);
        check_line("old buffer mid-frame", 511);
        check_line("old buffer mid-frame", 359);
        boundary(); do_swap();
        check_line("timeout", 359);
        check("timeout s0 pixel", int'(line_res[0]), 1);
        check_line("timeout", 360);

        // Freeze raised during capture: capture completes, swap withheld
        push(0);
        push(t4[0]); back[0] = t4[0];
        for (int i = 1; i < H; i++) begin
            if (i == 6) sw = 1'b1;
            push(t4[i]);
            back[i] = t4[i];
        end
        check("freeze busy", int'(capture_busy), 0);
        for (int f = 0; f < 3; f++) begin
            boundary();
            check($sformatf("frozen busy f%0d", f), int'(capture_busy), 0);
            check_line($sformatf("frozen f%0d", f), 359);
        end
        push(1000);
        check("tick in DONE ignored", int'(capture_busy), 0);

        // Release freeze: swap at the boundary, tick in the same clk dropped
        sw = 1'b0;
        hc = '0; vc = 12'(V);
        sample_tick = 1'b1; wave_sample = 10'd0;
        step();
        sample_tick = 1'b0;
        idle_coords();
        do_swap();
        push(0);
        for (int k = 0; k < 32; k++) push(1000);
        check("dropped ticks no trigger", int'(capture_busy), 1);

        // Hand-computed trace pixels around the 100 -> 900 step and extremes
        for (int i = 0; i < 17; i++) begin
            scan_line(vecs[i].y);
            check($sformatf("vec%0d x=%0d y=%0d", i, vecs[i].x, vecs[i].y),
                  int'(line_res[vecs[i].x]), vecs[i].exp);
        end
        check_line("step trace", 500);

        // Asynchronous reset in the middle of a capture
        push(0);
        push(1000);
        push(1000); push(1000); push(1000);
        hc = '0; vc = 12'd23;
        step(); step(); step();
        check("pixel before reset", int'(wave_cond), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset wave_cond", int'(wave_cond), 0);
        check("async reset busy", int'(capture_busy), 0);
        disp_valid = 1'b0;
        idle_coords();
        step(); step();
        resetn = 1'b1;
        step();
        check_line("blank after reset", 23);
        push(0);
        push(1000); back[0] = 1000;
        for (int i = 1; i < H; i++) begin
            push(1000);
            back[i] = 1000;
        end
        check("recapture busy", int'(capture_busy), 0);
        check_line("still blank before swap", 23);
        boundary(); do_swap();
        check_line("recovered", 23);
        check("recovered s0 pixel", int'(line_res[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wave_capture
`default_nettype wire

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Upstream producer of `wave_cond` for the grid/axis overlay stage.
- Captures one screen-width of audio samples, starting at a rising-edge trigger, into a double-buffered sample memory.
- Reads the displayed buffer back in raster order and asserts `wave_cond` on pixels covered by the waveform trace.
- Sits between the sample source (mic/ADC path) and the grid overlay, in the VGA pixel clock domain.

Parameters:
H_RES, 1280, samples per capture and visible pixels per line
V_RES, 1024, visible lines
TRIG_LEVEL, 512, trigger threshold on the 10-bit sample
TRIG_HYST, 8, hysteresis below TRIG_LEVEL required to arm the trigger
TRIG_TIMEOUT, 4096, sample ticks in ARMED before forcing a capture (auto mode)

Ports:
clk  in  1  VGA pixel clock
resetn  in  1  asynchronous active-low reset
sample_tick  in  1  one-clk pulse per new audio sample (clk_sample edge, already synchronised into clk)
wave_sample  in  10  unsigned sample, valid when sample_tick=1
switch  in  1  freeze: 1 = hold the displayed waveform
VGA_HORZ_COORD  in  12  current pixel x
VGA_VERT_COORD  in  12  current pixel y
wave_cond  out  1  pixel lies on the trace (2-clk latency vs coords)
capture_busy  out  1  state is ARMED or CAPTURING

Behaviour:
- Clock and reset: one clock, `clk`. Reset `resetn` is asynchronous, active-low.
- Reset values:
  - `wave_cond` = 0, `capture_busy` = 0.
  - State = IDLE; write pointer = 0; timeout counter = 0.
  - Display buffer select = 0; `armed_low` = 0.
  - Memory contents are undefined. `wave_cond` is gated by the `buf_valid` flag, which resets to 0 and is set on the first swap.
- FSM states:
  - IDLE -> ARMED on the next clk.
  - ARMED:
    - On a `sample_tick` with sample < TRIG_LEVEL-TRIG_HYST, set `armed_low`.
    - On a `sample_tick` with `armed_low`=1 and sample >= TRIG_LEVEL, write that sample at address 0 and go to CAPTURING with pointer = 1.
    - The timeout counter counts ticks. When it reaches TRIG_TIMEOUT-1 on a tick, write that sample at address 0 and go to CAPTURING.
    - Trigger takes priority when both conditions hit on the same tick (identical action).
  - CAPTURING:
    - Each `sample_tick` writes the sample to the back buffer at the pointer, then increments the pointer.
    - The write at pointer H_RES-1 moves to DONE.
  - DONE:
    - Waits for frame boundary: HORZ=0 and VERT=V_RES (first blanking line). Then, if `switch`=0: toggle buffer select, set `buf_valid`, go to IDLE.
    - If `switch`=1, stay in DONE indefinitely. No new capture runs and the display is unchanged.
  - On entry to ARMED, clear the timeout counter and `armed_low`.
- Swap timing: the swap occurs only at the frame boundary, so no frame is ever drawn from two buffers.
- Read path:
  - Read address = VGA_HORZ_COORD when HORZ < H_RES, else hold.
  - Stage 1: registered RAM read of sample s[x]; also register the previous column's value s[x-1]. For x=0, s[x-1] = s[0].
  - Stage 2 (y mapping): y_cur = 1023 - s[x], y_prev = 1023 - s[x-1], all 10-bit unsigned, no overflow.
  - Stage 2 (output): `wave_cond` = `buf_valid` AND HORZ_d2 < H_RES AND VERT_d2 < V_RES AND min(y_cur,y_prev) <= VERT_d2 <= max(y_cur,y_prev). This gives a vertically connected trace.
  - Coords are delayed 2 clks internally. The integration delays the grid-stage coords by 2 to match.
- Boundary conditions:
  - `sample_tick` asserted in the same clk as the DONE->IDLE swap is dropped.
  - A tick in IDLE is ignored.
  - Reset mid-capture abandons the back buffer. The display goes blank until the next completed swap.
  - `switch` rising during CAPTURING lets the capture complete; the swap is then withheld.
  - Sample 1023 maps to y=0 and sample 0 maps to y=1023. Both are drawable.

Decomposition:
- Shared package `wave_pkg`:
  - `state_t` enum (IDLE, ARMED, CAPTURING, DONE).
  - Constants H_RES, V_RES, SAMPLE_W=10.
  - Function `sample_to_y`.
- One sub-module `wave_dpram`: dual-port RAM, 2*H_RES x 10, synchronous write/read, 1-clk read latency. Address MSB = buffer select.

Test Plan:
- Ramp input 0..1023 repeating, `switch`=0 -> capture starts at the first tick reaching 512 after a value <504. Displayed s[0] >= 512; `wave_cond`=1 at (x=0, y=1023-s[0]) two clks after the coords.
- Constant input 600 (never below 504) -> no trigger. Capture starts exactly at tick 4096 of ARMED; `capture_busy` falls 1280 ticks later.
- Capture completes mid-frame -> the displayed buffer changes only at HORZ=0, VERT=1024. Every pixel of the current frame matches the old buffer.
- `switch`=1 during CAPTURING -> state holds in DONE and `wave_cond` pattern stays identical across 3 frames. Releasing `switch` -> swap at the next frame boundary.
- Consecutive samples 100 then 900 at x=9,10 -> at x=10, `wave_cond`=1 for VERT 123..923 inclusive and 0 at 122 and 924.
- Assert `resetn` low mid-CAPTURING -> `wave_cond`=0 and `capture_busy`=0 immediately (async). After release, the display stays blank until the first swap.
